// File: rtl/slow_clock_monitor.sv
// slow_clock_monitor
//   Receives an asynchronous slow square wave in the clk_in domain. It emits
//   single-cycle edge strobes, measures the rise-to-rise period in clk_in
//   cycles, and flags loss of the signal.
//
// Optional feature macro: SLOW_CLOCK_MONITOR_FALL_EDGE_EN
//   When the macro is defined, fall_pulse is generated and high_time is measured.
//   When it is undefined, both outputs are tied to 0.
//
// Parameters:
//   CNT_W          width of the cycle counter, period and high_time
//   TIMEOUT_CYCLES cycles without a rise before timeout asserts (< 2^CNT_W)
// Ports:
//   clk_in        system clock
//   reset         synchronous active-low reset
//   slow_in       asynchronous slow input
//   rise_pulse    one-cycle strobe per rising edge of slow_in
//   fall_pulse    one-cycle strobe per falling edge of slow_in
//   period        last rise-to-rise interval, in clk_in cycles
//   period_valid  one-cycle strobe, coincident with rise_pulse, when period updates
//   high_time     last rise-to-fall interval, in clk_in cycles
//   locked        at least one valid period measured since reset or timeout
//   timeout       no rise seen for TIMEOUT_CYCLES cycles
module slow_clock_monitor #(
  parameter int unsigned CNT_W          = 32,
  parameter int unsigned TIMEOUT_CYCLES = 100_000_000
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             slow_in,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic [CNT_W-1:0] high_time,
  output logic             locked,
  output logic             timeout
);

  localparam logic [CNT_W-1:0] TC    = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] TC_M1 = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_MEASURE, ST_TIMEOUT} state_t;

  state_t           state, state_d;
  logic             s1, s2, s3;
  logic             rise_det;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic             tc_hit;
  logic [CNT_W-1:0] period_d;
  logic             period_valid_d, locked_d, timeout_d;

  // The FSM decides one cycle ahead of the registered strobes, so cnt_d
  // (the value cnt will hold during the strobe) is the measured interval.
  always_comb begin
    rise_det       = s2 & ~s3;
    cnt_d          = rise_pulse ? CNT_W'(1) : ((cnt == TC) ? cnt : cnt + CNT_W'(1));
    // cnt_d reaches the terminal count this cycle; a coincident rise wins
    tc_hit         = (cnt == TC_M1) && !rise_pulse;
    state_d        = state;
    period_d       = period;
    period_valid_d = 1'b0;
    locked_d       = locked;
    timeout_d      = timeout;
    case (state)
      ST_IDLE: begin
        if (rise_det) begin
          state_d = ST_MEASURE;
        end else if (tc_hit) begin
          state_d   = ST_TIMEOUT;
          timeout_d = 1'b1;
        end
      end
      ST_MEASURE: begin
        if (rise_det) begin
          period_d       = cnt_d;
          period_valid_d = 1'b1;
          locked_d       = 1'b1;
        end else if (tc_hit) begin
          state_d   = ST_TIMEOUT;
          timeout_d = 1'b1;
          locked_d  = 1'b0;
        end
      end
      ST_TIMEOUT: begin
        // The interval ending at this rise is meaningless, so no period_valid
        if (rise_det) begin
          state_d   = ST_MEASURE;
          timeout_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Synchroniser, counter, FSM state and registered outputs
  always_ff @(posedge clk_in) begin
    if (!reset) begin
      s1           <= 1'b0;
      s2           <= 1'b0;
      s3           <= 1'b0;
      cnt          <= '0;
      state        <= ST_IDLE;
      rise_pulse   <= 1'b0;
      period       <= '0;
      period_valid <= 1'b0;
      locked       <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      s1           <= slow_in;
      s2           <= s1;
      s3           <= s2;
      cnt          <= cnt_d;
      state        <= state_d;
      rise_pulse   <= rise_det;
      period       <= period_d;
      period_valid <= period_valid_d;
      locked       <= locked_d;
      timeout      <= timeout_d;
    end
  end

`ifdef SLOW_CLOCK_MONITOR_FALL_EDGE_EN
  logic             fall_det;
  logic [CNT_W-1:0] high_time_d;

  // High time is the number of cycles from rise_pulse to fall_pulse
  always_comb begin
    fall_det    = ~s2 & s3;
    high_time_d = high_time;
    if (fall_det && (state == ST_MEASURE)) begin
      high_time_d = cnt_d;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!reset) begin
      fall_pulse <= 1'b0;
      high_time  <= '0;
    end else begin
      fall_pulse <= fall_det;
      high_time  <= high_time_d;
    end
  end
`else
  assign fall_pulse = 1'b0;
  assign high_time  = '0;
`endif

endmodule

// File: tb/tb_slow_clock_monitor.sv
// Directed bench for slow_clock_monitor with TIMEOUT_CYCLES = 64.
// Each rising edge that is driven pushes its expected period_valid, period
// and locked values. The monitor pops the entry and compares it on rise_pulse.
module tb_slow_clock_monitor;
  localparam int unsigned CNT_W = 32;
  localparam int unsigned TO    = 64;

  logic             clk_in = 1'b0;
  logic             reset = 1'b0;
  logic             slow_in = 1'b0;
  logic             rise_pulse, fall_pulse, period_valid, locked, timeout;
  logic [CNT_W-1:0] period, high_time;

  slow_clock_monitor #(.CNT_W(CNT_W), .TIMEOUT_CYCLES(TO)) dut (
    .clk_in(clk_in), .reset(reset), .slow_in(slow_in),
    .rise_pulse(rise_pulse), .fall_pulse(fall_pulse),
    .period(period), .period_valid(period_valid), .high_time(high_time),
    .locked(locked), .timeout(timeout)
  );

  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  typedef struct {
    logic             pv;
    logic [CNT_W-1:0] per;
    logic             lk;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   last_k = 0;
  bit   first = 1'b1;
  logic prev_in = 1'b0;
  int   falls = 0;
  int   fall_cnt = 0;
  bit   lenient = 1'b0;
  int   glitch_rises = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard side: pop an entry on each rise_pulse and compare it
  always @(negedge clk_in) begin
    exp_t e;
    chk("pv_needs_rise", 64'(period_valid & ~rise_pulse), 64'(0));
    if (fall_pulse === 1'b1) fall_cnt++;
    if (rise_pulse === 1'b1) begin
      if (lenient) begin
        glitch_rises++;
      end else if (q.size() == 0) begin
        chk("unexpected_rise", 64'(1), 64'(0));
      end else begin
        e = q.pop_front();
        chk("period_valid", 64'(period_valid), 64'(e.pv));
        if (e.pv) chk("period", 64'(period), 64'(e.per));
        chk("locked_at_rise", 64'(locked), 64'(e.lk));
        chk("timeout_at_rise", 64'(timeout), 64'(0));
      end
    end
  end

  // Drive slow_in to level v for n cycles; called just after a rising clock edge
  task automatic hold(input logic v, input int n);
    exp_t e;
    int k;
    if (v && !prev_in) begin
      k    = cyc + 1;
      e.pv = !first;
      e.per = CNT_W'(k - last_k);
      e.lk = !first;
      q.push_back(e);
      first  = 1'b0;
      last_k = k;
    end
    if (!v && prev_in) falls++;
    prev_in = v;
    slow_in = v;
    repeat (n) begin
      @(posedge clk_in);
      #1;
    end
  endtask

  task automatic do_reset(input int n);
    reset   = 1'b0;
    slow_in = 1'b0;
    prev_in = 1'b0;
    repeat (n) @(posedge clk_in);
    @(negedge clk_in);
    chk("rst_rise_pulse", 64'(rise_pulse), 64'(0));
    chk("rst_fall_pulse", 64'(fall_pulse), 64'(0));
    chk("rst_period", 64'(period), 64'(0));
    chk("rst_period_valid", 64'(period_valid), 64'(0));
    chk("rst_high_time", 64'(high_time), 64'(0));
    chk("rst_locked", 64'(locked), 64'(0));
    chk("rst_timeout", 64'(timeout), 64'(0));
    chk("rst_queue_drained", 64'(q.size()), 64'(0));
    @(posedge clk_in);
    #1;
    reset = 1'b1;
    first = 1'b1;
  endtask

  task automatic check_falls(input string tag);
`ifdef SLOW_CLOCK_MONITOR_FALL_EDGE_EN
    chk(tag, 64'(fall_cnt), 64'(falls));
`else
    chk(tag, 64'(fall_cnt), 64'(0));
`endif
  endtask

  initial begin
    int target;
    // Reset, then check the first rise and its 3-cycle latency
    do_reset(5);
    hold(1'b1, 1);
    @(negedge clk_in);
    @(negedge clk_in);
    chk("rise_latency_early", 64'(rise_pulse), 64'(0));
    @(negedge clk_in);
    chk("rise_latency", 64'(rise_pulse), 64'(1));
    chk("first_rise_locked", 64'(locked), 64'(0));
    @(posedge clk_in);
    #1;
    hold(1'b1, 1);
    hold(1'b0, 5);

    // Steady 5/5 toggling, period 10
    for (int i = 0; i < 4; i++) begin
      hold(1'b1, 5);
      hold(1'b0, 5);
    end

    // 3 high / 7 low: high_time 3, period 10
    for (int i = 0; i < 3; i++) begin
      hold(1'b1, 3);
      hold(1'b0, 7);
    end
`ifdef SLOW_CLOCK_MONITOR_FALL_EDGE_EN
    chk("high_time", 64'(high_time), 64'(3));
`else
    chk("high_time_tied", 64'(high_time), 64'(0));
`endif
    check_falls("fall_count_a");

    // Period equal to TIMEOUT_CYCLES: the rise coincides with the terminal count and wins
    hold(1'b1, 5);
    hold(1'b0, 59);
    hold(1'b1, 5);
    hold(1'b0, 5);
    hold(1'b1, 5);

    // Timeout exactly TO cycles after the last rise_pulse
    hold(1'b0, 1);
    target = last_k + 1 + int'(TO);
    for (int i = 0; i < 200 && cyc != target; i++) @(negedge clk_in);
    chk("timeout_wait", 64'(cyc), 64'(target));
    chk("timeout_before", 64'(timeout), 64'(0));
    chk("locked_before_timeout", 64'(locked), 64'(1));
    @(negedge clk_in);
    chk("timeout_at_tc", 64'(timeout), 64'(1));
    chk("locked_cleared", 64'(locked), 64'(0));
    repeat (10) @(negedge clk_in);
    chk("timeout_held", 64'(timeout), 64'(1));
    @(posedge clk_in);
    #1;
    first = 1'b1;

    // Resume: the first rise clears timeout without period_valid; the next rise is valid
    hold(1'b1, 5);
    hold(1'b0, 5);
    hold(1'b1, 5);
    hold(1'b0, 5);

    // Reset 20 cycles into a period-60 measurement (high 10 / low 50)
    hold(1'b1, 10);
    hold(1'b0, 10);
    do_reset(5);
    hold(1'b0, 5);
    hold(1'b1, 10);
    hold(1'b0, 50);
    hold(1'b1, 10);
    hold(1'b0, 50);
    hold(1'b1, 10);
    hold(1'b0, 10);
    check_falls("fall_count_b");

    // Single-cycle glitch: at most one rise and no X on the outputs
    lenient = 1'b1;
    slow_in = 1'b1;
    @(posedge clk_in);
    #1;
    slow_in = 1'b0;
    repeat (6) begin
      @(posedge clk_in);
      #1;
    end
    lenient = 1'b0;
    chk("glitch_rises_le1", 64'(glitch_rises <= 1), 64'(1));
    chk("glitch_no_x", 64'($isunknown({rise_pulse, fall_pulse, period, period_valid,
                                       high_time, locked, timeout})), 64'(0));

    // Recovery after reset
    do_reset(3);
    hold(1'b1, 5);
    hold(1'b0, 5);
    hold(1'b1, 5);
    hold(1'b0, 5);
    chk("queue_drained", 64'(q.size()), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
